// File: rtl/tx_fifo_fwft_out.sv
// tx_fifo_fwft_out: two-entry output/skid register stage for a first-word-fall-through stream.
//   i_clk, i_rst       clock and synchronous active-high reset
//   in_valid, in_data  word returning from the RAM this cycle
//   occ                words currently held (0..2)
//   valid, ready, data downstream stream; data is the registered head word
module tx_fifo_fwft_out #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [1:0]            occ,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data
);
  logic                  out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic                  pop, kept_v, kept_skid_v, to_skid;
  logic [DATA_WIDTH-1:0] kept_d;
  // kept_* describe the stage after the pop and skid->out refill, before the new word lands
  always_comb begin
    pop         = out_v_q & ready;
    kept_v      = (out_v_q & ~pop) | (pop & skid_v_q);
    kept_d      = (pop & skid_v_q) ? skid_q : out_q;
    kept_skid_v = skid_v_q & ~pop;
    to_skid     = in_valid & kept_v;
    out_v_d     = kept_v | in_valid;
    out_d       = kept_v ? kept_d : (in_valid ? in_data : out_q);
    skid_v_d    = kept_skid_v | to_skid;
    skid_d      = to_skid ? in_data : skid_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
    end
  end
  assign valid = out_v_q;
  assign data  = out_q;
  assign occ   = {1'b0, out_v_q} + {1'b0, skid_v_q};
endmodule

// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl: single-clock FIFO controller driving an external dp_ram with a FWFT output stream.
//   i_clk, i_rst                 clock and synchronous active-high reset
//   i_wvalid, o_wready, i_wdata  producer side; write accepted on i_wvalid & o_wready
//   o_rvalid, i_rready, o_rdata  consumer side; word taken on o_rvalid & i_rready
//   o_count                      words held in RAM, in flight and in the output stage
//   o_ram_*                      write/read strobes, addresses and data to dp_ram
//   i_ram_rdata                  dp_ram read data, valid the cycle after o_ram_ren
module tx_fifo_ctrl #(
  parameter  int RAM_DEPTH  = 1024,
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 10,
  localparam int CNT_WIDTH  = $clog2(RAM_DEPTH + 3)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_ram_wen,
  output logic [ADDR_WIDTH-1:0] o_ram_waddr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_ren,
  output logic [ADDR_WIDTH-1:0] o_ram_raddr,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic                  inflight_q;
  logic [1:0]            occ;
  logic [2:0]            ahead;
  logic                  pop, issue;
  // pointers wrap at RAM_DEPTH, which need not be a power of two
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
  endfunction
  // a read is issued only if its word will have a free slot in out/skid on return;
  // full is judged on the registered count so a same-cycle issue never frees a slot early
  always_comb begin
    o_wready  = ~i_rst && (ram_cnt_q < CNT_WIDTH'(RAM_DEPTH));
    o_ram_wen = i_wvalid & o_wready;
    pop       = o_rvalid & i_rready;
    ahead     = 3'(occ) + 3'(inflight_q) - 3'(pop);
    issue     = (ram_cnt_q != '0) && (ahead < 3'd2);
    wptr_d    = o_ram_wen ? ptr_inc(wptr_q) : wptr_q;
    rptr_d    = issue ? ptr_inc(rptr_q) : rptr_q;
    ram_cnt_d = ram_cnt_q + CNT_WIDTH'(o_ram_wen) - CNT_WIDTH'(issue);
    count_d   = count_q + CNT_WIDTH'(o_ram_wen) - CNT_WIDTH'(pop);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      inflight_q <= issue;
    end
  end
  tx_fifo_fwft_out #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .in_valid (inflight_q),
    .in_data  (i_ram_rdata),
    .occ      (occ),
    .valid    (o_rvalid),
    .ready    (i_rready),
    .data     (o_rdata)
  );
  assign o_ram_waddr = wptr_q;
  assign o_ram_wdata = i_wdata;
  assign o_ram_ren   = issue;
  assign o_ram_raddr = rptr_q;
  assign o_count     = count_q;
endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// tb_tx_fifo_ctrl: directed bench for tx_fifo_ctrl at depths 4 and 5 with behavioural dp_ram models.
module tb_tx_fifo_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst, wvalid, rready;
  logic [7:0] wdata;
  logic       wready4, rvalid4, wen4, ren4, wready5, rvalid5, wen5, ren5;
  logic [7:0] rdata4, ram_wdata4, ram_rdata4, rdata5, ram_wdata5, ram_rdata5;
  logic [2:0] count4, count5, waddr5, raddr5;
  logic [1:0] waddr4, raddr4;
  logic [7:0] mem4 [4];
  logic [7:0] mem5 [8];
  logic [7:0] q4 [$];
  logic [7:0] q5 [$];
  int n_cmp = 0, n_err = 0, n_acc5 = 0, n_pop5 = 0, max_wa5 = 0;
  tx_fifo_ctrl #(.RAM_DEPTH(4), .DATA_WIDTH(8), .ADDR_WIDTH(2)) u_d4 (
    .i_clk(clk), .i_rst(rst), .i_wvalid(wvalid), .o_wready(wready4), .i_wdata(wdata),
    .o_rvalid(rvalid4), .i_rready(rready), .o_rdata(rdata4), .o_count(count4),
    .o_ram_wen(wen4), .o_ram_waddr(waddr4), .o_ram_wdata(ram_wdata4),
    .o_ram_ren(ren4), .o_ram_raddr(raddr4), .i_ram_rdata(ram_rdata4)
  );
  tx_fifo_ctrl #(.RAM_DEPTH(5), .DATA_WIDTH(8), .ADDR_WIDTH(3)) u_d5 (
    .i_clk(clk), .i_rst(rst), .i_wvalid(wvalid), .o_wready(wready5), .i_wdata(wdata),
    .o_rvalid(rvalid5), .i_rready(rready), .o_rdata(rdata5), .o_count(count5),
    .o_ram_wen(wen5), .o_ram_waddr(waddr5), .o_ram_wdata(ram_wdata5),
    .o_ram_ren(ren5), .o_ram_raddr(raddr5), .i_ram_rdata(ram_rdata5)
  );
  always @(posedge clk) begin
    if (wen4) mem4[waddr4] <= ram_wdata4;
    if (ren4) ram_rdata4 <= mem4[raddr4];
    if (wen5) mem5[waddr5] <= ram_wdata5;
    if (ren5) ram_rdata5 <= mem5[raddr5];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // one clock: settle, score the handshakes of this cycle, then advance to 1ns past the edge
  task automatic cyc();
    #1;
    if (rst) begin
      q4.delete();
      q5.delete();
    end else begin
      if (rvalid4 && rready) begin
        check("sb4_nonempty", q4.size() != 0, 1);
        if (q4.size() != 0) check("sb4_order", rdata4, q4.pop_front());
      end
      if (rvalid5 && rready) begin
        n_pop5++;
        check("sb5_nonempty", q5.size() != 0, 1);
        if (q5.size() != 0) check("sb5_order", rdata5, q5.pop_front());
      end
      if (wvalid && wready4) q4.push_back(wdata);
      if (wvalid && wready5) begin
        q5.push_back(wdata);
        n_acc5++;
        if (int'(waddr5) > max_wa5) max_wa5 = int'(waddr5);
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_v, gaps4, gaps5, badc, cycles;
    logic [7:0] prev;
    logic stalled;
    rst = 1'b1; wvalid = 1'b0; rready = 1'b0; wdata = '0;
    @(posedge clk);
    #1;
    cyc();
    cyc();
    check("rst_wready", wready4, 0);
    check("rst_rvalid", rvalid4, 0);
    check("rst_count", count4, 0);
    check("rst_rdata", rdata4, 0);
    rst = 1'b0;
    // single word latency
    wvalid = 1'b1; wdata = 8'hA5; rready = 1'b1;
    cyc();
    wvalid = 1'b0;
    check("t1_wready", wready4, 1);
    check("t1_cnt_acc", count4, 1);
    check("t1_rv_n0", rvalid4, 0);
    cyc();
    check("t1_rv_n1", rvalid4, 0);
    cyc();
    check("t1_rv_n2", rvalid4, 1);
    check("t1_data", rdata4, 8'hA5);
    check("t1_cnt_held", count4, 1);
    cyc();
    check("t1_rv_pop", rvalid4, 0);
    check("t1_cnt_pop", count4, 0);
    check("t1_cnt5_pop", count5, 0);
    // fill with no consumer
    rready = 1'b0; wvalid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      wdata = 8'(i);
      cyc();
    end
    wvalid = 1'b0;
    check("t2_cnt4", count4, 6);
    check("t2_wready4", wready4, 0);
    check("t2_cnt5", count5, 7);
    check("t2_wready5", wready5, 0);
    check("t2_head", rdata4, 1);
    rready = 1'b1; exp_v = 1;
    for (int i = 0; i < 12; i++) begin
      if (rvalid4) begin
        check("t2_drain", rdata4, exp_v);
        exp_v++;
      end
      cyc();
    end
    check("t2_ndrained", exp_v, 7);
    check("t2_cnt4_end", count4, 0);
    check("t2_cnt5_end", count5, 0);
    // simultaneous streaming
    wvalid = 1'b1; rready = 1'b1; gaps4 = 0; gaps5 = 0; badc = 0;
    for (int i = 0; i < 1000; i++) begin
      wdata = 8'(i);
      cyc();
      if (i >= 2) begin
        if (!rvalid4) gaps4++;
        if (!rvalid5) gaps5++;
        if (count4 != 3 || count5 != 3) badc++;
      end
    end
    check("t3_gaps4", gaps4, 0);
    check("t3_gaps5", gaps5, 0);
    check("t3_cnt_unstable", badc, 0);
    wvalid = 1'b0;
    repeat (6) cyc();
    check("t3_cnt4_end", count4, 0);
    check("t3_cnt5_end", count5, 0);
    // random traffic, non power-of-two depth
    n_acc5 = 0; n_pop5 = 0; max_wa5 = 0; cycles = 0;
    while (n_acc5 < 10000 && cycles < 60000) begin
      wvalid = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
      wdata = 8'($urandom);
      cyc();
      cycles++;
    end
    check("t4_words", n_acc5, 10000);
    wvalid = 1'b0; rready = 1'b1;
    repeat (12) cyc();
    check("t4_popped", n_pop5, n_acc5);
    check("t4_max_waddr", max_wa5, 4);
    check("t4_cnt5_end", count5, 0);
    check("t4_cnt4_end", count4, 0);
    // reset mid-operation
    rready = 1'b0; wvalid = 1'b1;
    wdata = 8'h11; cyc();
    wdata = 8'h22; cyc();
    wdata = 8'h33; cyc();
    wvalid = 1'b0;
    repeat (3) cyc();
    check("t5_cnt_pre", count4, 3);
    check("t5_rv_pre", rvalid4, 1);
    rst = 1'b1;
    cyc();
    check("t5_rv_rst", rvalid4, 0);
    check("t5_cnt_rst", count4, 0);
    check("t5_wready_rst", wready4, 0);
    rst = 1'b0; wvalid = 1'b1; wdata = 8'h3C; rready = 1'b1;
    cyc();
    wvalid = 1'b0;
    for (int k = 0; k < 5 && !rvalid4; k++) cyc();
    check("t5_rv_timeout", rvalid4, 1);
    check("t5_first", rdata4, 8'h3C);
    cyc();
    check("t5_cnt_end", count4, 0);
    // backpressure on a full FIFO
    rready = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'h40 + 8'(i);
      cyc();
    end
    check("t6_full", count4, 6);
    for (int i = 0; i < 30; i++) begin
      wdata = 8'h60 + 8'(i);
      rready = (i % 3 == 0);
      prev = rdata4;
      stalled = rvalid4 & ~rready;
      cyc();
      if (stalled) check("t6_hold", rdata4, prev);
      check("t6_stage_le2", (u_d4.occ + u_d4.inflight_q) <= 2, 1);
      check("t6_cnt_le6", count4 <= 6, 1);
    end
    wvalid = 1'b0; rready = 1'b1;
    repeat (12) cyc();
    check("t6_cnt4_end", count4, 0);
    check("t6_cnt5_end", count5, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
